id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register of the 5-stage RV32I core; captures decoded operands and controls each cycle.
//  Its outputs drive the EX operand-select muxes (ALU src A/B) and the ALU directly.
//  Contains load-use hazard detection and inserts exactly one bubble per hazard.
//  Applies external stall (hold) and flush (branch/jump redirect).
// PARAMETERS
//  XLEN   32  datapath width (pc, rs1/rs2 data, imm)
//  CNT_W  32  width of bubble counter (PERF_CNT_EN only)
// PORTS
//  clk_i            in   1     core clock; all state on rising edge
//  rst_i            in   1     synchronous, active-high reset
//  stall_i          in   1     hold ID/EX contents (downstream wait)
//  flush_i          in   1     kill ID/EX contents (taken branch/jump in EX)
//  id_valid_i       in   1     ID stage holds a real instruction
//  id_pc_i          in   XLEN  instruction PC
//  id_rs1_data_i    in   XLEN  register-file read A
//  id_rs2_data_i    in   XLEN  register-file read B
//  id_imm_i         in   XLEN  sign-extended immediate
//  id_rs1_i, id_rs2_i, id_rd_i   in  5 each  register addresses
//  id_alu_ctrl_i    in   4     ALU operation code
//  id_alu_src_a_i   in   1     0=rs1, 1=pc (sel for EX mux A)
//  id_alu_src_b_i   in   1     0=rs2, 1=imm (sel for EX mux B)
//  id_reg_we_i, id_mem_re_i, id_mem_we_i, id_branch_i, id_jump_i  in  1 each
//  id_wb_sel_i      in   2     00=ALU 01=mem 10=pc+4 11=reserved
//  ex_*_o           out  same  registered copies of every id_* input above (ex_valid_o .. ex_wb_sel_o)
//  hazard_o         out  1     combinational load-use stall request to PC and IF/ID
//  perf_bubble_cnt_o out CNT_W bubbles inserted (only when PERF_CNT_EN defined)
// BEHAVIOUR
//  - Latency 1 cycle ID->EX; no combinational path from id_* to ex_*_o.
//  - Reset: every ex_*_o = 0 (ex_valid_o=0, all controls 0); counter = 0; hazard_o then 0.
//  - hazard_o = id_valid_i & ex_valid_o & ex_mem_re_o & (ex_rd_o!=0) & (ex_rd_o==id_rs1_i | ex_rd_o==id_rs2_i).
//  - Per-edge priority: rst_i > flush_i > stall_i > hazard_o > load.
//    flush: load bubble. stall: hold all ex_*_o (hazard_o still evaluated from held values).
//    hazard: load bubble; upstream holds ID, so instr re-presents next cycle.
//    load: ex_* <= id_*.
//  - Bubble: ex_valid_o=0, reg_we/mem_re/mem_we/branch/jump=0, alu_ctrl=0, wb_sel=00; data/address fields 0.
//  - Bubble clears ex_mem_re_o, so one hazard yields exactly one bubble cycle (no deadlock).
//  - id_valid_i=0 loads as bubble (controls forced 0 regardless of id_* controls).
//  - rd=x0 never triggers hazard; rs1 and rs2 both matching counts as one hazard.
//  - flush_i & hazard_o same cycle: flush wins, counted as flush, not bubble.
// CONFIGURATION
//  PERF_CNT_EN defined: perf_bubble_cnt_o exists; +1 on each hazard-bubble edge
//    (not flush, not stall); saturates at 2**CNT_W-1; cleared only by rst_i.
//  PERF_CNT_EN undefined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package riscv_pipe_pkg: XLEN, REG_ADDR_W=5, ALU_CTRL_W=4, ALU op encodings,
//    WB_SEL_{ALU,MEM,PC4} encodings, ctrl bundle typedef and its bubble constant.
//  Sub-module load_use_detect: pure combinational hazard_o from ex_valid/mem_re/rd and id rs1/rs2/valid.
//  Top: one registered ctrl bundle + data fields, priority mux, optional counter.
// TESTING
//  1 Reset: hold rst_i 2 cycles with id_* random -> all ex_*_o=0, hazard_o=0, counter=0.
//  2 Pass-through: pc=0x100, rs1_data=0xDEADBEEF, imm=0xFFFFFFFC, reg_we=1 -> same values on ex_*_o next edge.
//  3 Load-use: EX lw rd=5; ID add rs1=5 -> hazard_o=1, next edge ex_valid_o=0, then add loads; cnt=1.
//  4 x0 / no-match: EX lw rd=0, ID rs1=0 -> hazard_o=0; EX lw rd=6, ID rs1=5,rs2=7 -> hazard_o=0.
//  5 Stall: stall_i=1 for 3 cycles with changing id_* -> ex_*_o unchanged; release -> loads current id_*.
//  6 Flush vs stall/hazard: flush_i=stall_i=1 with hazard -> bubble, cnt unchanged; saturate at CNT_W=4 -> stays 15.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the RV32I core: widths, ALU/WB encodings,
// the ID/EX control bundle and its bubble value.
package riscv_pipe_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALU_CTRL_W = 4;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLL  = 4'h2,
        ALU_SLT  = 4'h3,
        ALU_SLTU = 4'h4,
        ALU_XOR  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_OR   = 4'h8,
        ALU_AND  = 4'h9,
        ALU_LUI  = 4'hA
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'b00,
        WB_SEL_MEM = 2'b01,
        WB_SEL_PC4 = 2'b10
    } wb_sel_e;

    // What the ID/EX register does on the coming edge, after priority resolution.
    typedef enum logic [2:0] {
        ACT_LOAD,
        ACT_EMPTY,
        ACT_HAZARD,
        ACT_HOLD,
        ACT_FLUSH
    } stage_act_e;

    typedef struct packed {
        logic                  valid;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic                  alu_src_a;
        logic                  alu_src_b;
        logic                  reg_we;
        logic                  mem_re;
        logic                  mem_we;
        logic                  branch;
        logic                  jump;
        logic [1:0]            wb_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load sitting in EX and the
// instruction currently decoded in ID.
module load_use_detect
    import riscv_pipe_pkg::*;
(
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_re_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    output logic                  hazard_o
);

    logic ex_is_load;
    logic rd_match;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign ex_is_load = ex_valid_i & ex_mem_re_i & (ex_rd_i != '0);
    assign rd_match   = (ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i);
    assign hazard_o   = id_valid_i & ex_is_load & rd_match;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, stall and flush.
// Optional bubble counter enabled by defining PERF_CNT_EN.
module id_ex_stage_reg
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned XLEN = riscv_pipe_pkg::XLEN
`ifdef PERF_CNT_EN
    , parameter int unsigned CNT_W = 32
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,

    input  logic                  id_valid_i,
    input  logic [XLEN-1:0]       id_pc_i,
    input  logic [XLEN-1:0]       id_rs1_data_i,
    input  logic [XLEN-1:0]       id_rs2_data_i,
    input  logic [XLEN-1:0]       id_imm_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic [ALU_CTRL_W-1:0] id_alu_ctrl_i,
    input  logic                  id_alu_src_a_i,
    input  logic                  id_alu_src_b_i,
    input  logic                  id_reg_we_i,
    input  logic                  id_mem_re_i,
    input  logic                  id_mem_we_i,
    input  logic                  id_branch_i,
    input  logic                  id_jump_i,
    input  logic [1:0]            id_wb_sel_i,

    output logic                  ex_valid_o,
    output logic [XLEN-1:0]       ex_pc_o,
    output logic [XLEN-1:0]       ex_rs1_data_o,
    output logic [XLEN-1:0]       ex_rs2_data_o,
    output logic [XLEN-1:0]       ex_imm_o,
    output logic [REG_ADDR_W-1:0] ex_rs1_o,
    output logic [REG_ADDR_W-1:0] ex_rs2_o,
    output logic [REG_ADDR_W-1:0] ex_rd_o,
    output logic [ALU_CTRL_W-1:0] ex_alu_ctrl_o,
    output logic                  ex_alu_src_a_o,
    output logic                  ex_alu_src_b_o,
    output logic                  ex_reg_we_o,
    output logic                  ex_mem_re_o,
    output logic                  ex_mem_we_o,
    output logic                  ex_branch_o,
    output logic                  ex_jump_o,
    output logic [1:0]            ex_wb_sel_o,

    output logic                  hazard_o
`ifdef PERF_CNT_EN
    , output logic [CNT_W-1:0]    perf_bubble_cnt_o
`endif
);

    ctrl_t      id_ctrl;
    ctrl_t      ex_ctrl;
    stage_act_e act;
    logic       hazard;

    load_use_detect u_load_use_detect (
        .ex_valid_i  (ex_ctrl.valid),
        .ex_mem_re_i (ex_ctrl.mem_re),
        .ex_rd_i     (ex_rd_o),
        .id_valid_i  (id_valid_i),
        .id_rs1_i    (id_rs1_i),
        .id_rs2_i    (id_rs2_i),
        .hazard_o    (hazard)
    );

    assign hazard_o = hazard;

    always_comb begin
        id_ctrl           = CTRL_BUBBLE;
        id_ctrl.valid     = id_valid_i;
        id_ctrl.alu_ctrl  = id_alu_ctrl_i;
        id_ctrl.alu_src_a = id_alu_src_a_i;
        id_ctrl.alu_src_b = id_alu_src_b_i;
        id_ctrl.reg_we    = id_reg_we_i;
        id_ctrl.mem_re    = id_mem_re_i;
        id_ctrl.mem_we    = id_mem_we_i;
        id_ctrl.branch    = id_branch_i;
        id_ctrl.jump      = id_jump_i;
        id_ctrl.wb_sel    = id_wb_sel_i;
    end

    // Priority below reset: flush > stall > hazard > load; an empty ID slot
    // loads as a bubble so stale controls never reach EX.
    always_comb begin
        act = ACT_LOAD;
        if (flush_i) begin
            act = ACT_FLUSH;
        end else if (stall_i) begin
            act = ACT_HOLD;
        end else if (hazard) begin
            act = ACT_HAZARD;
        end else if (!id_valid_i) begin
            act = ACT_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_ctrl       <= CTRL_BUBBLE;
            ex_pc_o       <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_rs1_o      <= '0;
            ex_rs2_o      <= '0;
            ex_rd_o       <= '0;
        end else begin
            case (act)
                ACT_LOAD: begin
                    ex_ctrl       <= id_ctrl;
                    ex_pc_o       <= id_pc_i;
                    ex_rs1_data_o <= id_rs1_data_i;
                    ex_rs2_data_o <= id_rs2_data_i;
                    ex_imm_o      <= id_imm_i;
                    ex_rs1_o      <= id_rs1_i;
                    ex_rs2_o      <= id_rs2_i;
                    ex_rd_o       <= id_rd_i;
                end
                ACT_HOLD: begin
                    ex_ctrl <= ex_ctrl;
                end
                default: begin
                    ex_ctrl       <= CTRL_BUBBLE;
                    ex_pc_o       <= '0;
                    ex_rs1_data_o <= '0;
                    ex_rs2_data_o <= '0;
                    ex_imm_o      <= '0;
                    ex_rs1_o      <= '0;
                    ex_rs2_o      <= '0;
                    ex_rd_o       <= '0;
                end
            endcase
        end
    end

    assign ex_valid_o     = ex_ctrl.valid;
    assign ex_alu_ctrl_o  = ex_ctrl.alu_ctrl;
    assign ex_alu_src_a_o = ex_ctrl.alu_src_a;
    assign ex_alu_src_b_o = ex_ctrl.alu_src_b;
    assign ex_reg_we_o    = ex_ctrl.reg_we;
    assign ex_mem_re_o    = ex_ctrl.mem_re;
    assign ex_mem_we_o    = ex_ctrl.mem_we;
    assign ex_branch_o    = ex_ctrl.branch;
    assign ex_jump_o      = ex_ctrl.jump;
    assign ex_wb_sel_o    = ex_ctrl.wb_sel;

`ifdef PERF_CNT_EN
    // Only genuine load-use bubbles count; flush and stall edges do not.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_bubble_cnt_o <= '0;
        end else if (act == ACT_HAZARD && perf_bubble_cnt_o != '1) begin
            perf_bubble_cnt_o <= perf_bubble_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg; counter checks apply
// only when PERF_CNT_EN is defined (counter built 4 bits wide).
module tb_id_ex_stage_reg;

    logic        clk;
    logic        rst_i, stall_i, flush_i;
    logic        id_valid_i;
    logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic [3:0]  id_alu_ctrl_i;
    logic        id_alu_src_a_i, id_alu_src_b_i, id_reg_we_i, id_mem_re_i;
    logic        id_mem_we_i, id_branch_i, id_jump_i;
    logic [1:0]  id_wb_sel_i;

    logic        ex_valid_o;
    logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic [3:0]  ex_alu_ctrl_o;
    logic        ex_alu_src_a_o, ex_alu_src_b_o, ex_reg_we_o, ex_mem_re_o;
    logic        ex_mem_we_o, ex_branch_o, ex_jump_o;
    logic [1:0]  ex_wb_sel_o;
    logic        hazard_o;
`ifdef PERF_CNT_EN
    logic [3:0]  perf_bubble_cnt_o;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    id_ex_stage_reg #(
        .XLEN(32)
`ifdef PERF_CNT_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rd_i(id_rd_i), .id_alu_ctrl_i(id_alu_ctrl_i),
        .id_alu_src_a_i(id_alu_src_a_i), .id_alu_src_b_i(id_alu_src_b_i),
        .id_reg_we_i(id_reg_we_i), .id_mem_re_i(id_mem_re_i),
        .id_mem_we_i(id_mem_we_i), .id_branch_i(id_branch_i),
        .id_jump_i(id_jump_i), .id_wb_sel_i(id_wb_sel_i),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_imm_o(ex_imm_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
        .ex_rd_o(ex_rd_o), .ex_alu_ctrl_o(ex_alu_ctrl_o),
        .ex_alu_src_a_o(ex_alu_src_a_o), .ex_alu_src_b_o(ex_alu_src_b_o),
        .ex_reg_we_o(ex_reg_we_o), .ex_mem_re_o(ex_mem_re_o),
        .ex_mem_we_o(ex_mem_we_o), .ex_branch_o(ex_branch_o),
        .ex_jump_o(ex_jump_o), .ex_wb_sel_o(ex_wb_sel_o),
        .hazard_o(hazard_o)
`ifdef PERF_CNT_EN
        , .perf_bubble_cnt_o(perf_bubble_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid_i = 0; id_pc_i = '0; id_rs1_data_i = '0; id_rs2_data_i = '0;
        id_imm_i = '0; id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
        id_alu_ctrl_i = '0; id_alu_src_a_i = 0; id_alu_src_b_i = 0;
        id_reg_we_i = 0; id_mem_re_i = 0; id_mem_we_i = 0; id_branch_i = 0;
        id_jump_i = 0; id_wb_sel_i = '0;
    endtask

    // Valid instruction: load when mem_re=1, otherwise plain ALU op writing rd.
    task automatic put_instr(input logic [31:0] pc, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic mem_re);
        clear_id();
        id_valid_i = 1; id_pc_i = pc; id_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
        id_mem_re_i = mem_re; id_reg_we_i = 1; id_wb_sel_i = mem_re ? 2'b01 : 2'b00;
        id_alu_src_b_i = mem_re;
    endtask

    initial begin
        rst_i = 1; stall_i = 0; flush_i = 0;
        clear_id();
        id_valid_i = 1; id_pc_i = $urandom; id_rs1_data_i = $urandom;
        id_rs2_data_i = $urandom; id_imm_i = $urandom; id_rd_i = 5'd9;
        id_reg_we_i = 1; id_mem_re_i = 1; id_jump_i = 1; id_wb_sel_i = 2'b10;
        id_alu_ctrl_i = 4'h7;
        step(); step();
        check_eq("rst_valid", ex_valid_o, 0);
        check_eq("rst_pc", ex_pc_o, 0);
        check_eq("rst_rd", ex_rd_o, 0);
        check_eq("rst_ctrl", {ex_alu_ctrl_o, ex_reg_we_o, ex_mem_re_o, ex_jump_o, ex_wb_sel_o}, 0);
        check_eq("rst_hazard", hazard_o, 0);
`ifdef PERF_CNT_EN
        check_eq("rst_cnt", perf_bubble_cnt_o, 0);
`endif
        rst_i = 0;

        // Pass-through
        clear_id();
        id_valid_i = 1; id_pc_i = 32'h100; id_rs1_data_i = 32'hDEADBEEF;
        id_rs2_data_i = 32'h12345678; id_imm_i = 32'hFFFFFFFC; id_reg_we_i = 1;
        id_rs1_i = 1; id_rs2_i = 2; id_rd_i = 3; id_alu_ctrl_i = 4'h1;
        id_alu_src_b_i = 1; id_branch_i = 1;
        step();
        check_eq("pt_valid", ex_valid_o, 1);
        check_eq("pt_pc", ex_pc_o, 32'h100);
        check_eq("pt_rs1_data", ex_rs1_data_o, 32'hDEADBEEF);
        check_eq("pt_rs2_data", ex_rs2_data_o, 32'h12345678);
        check_eq("pt_imm", ex_imm_o, 32'hFFFFFFFC);
        check_eq("pt_regs", {ex_rs1_o, ex_rs2_o, ex_rd_o}, {5'd1, 5'd2, 5'd3});
        check_eq("pt_ctrl", {ex_alu_ctrl_o, ex_alu_src_a_o, ex_alu_src_b_o, ex_reg_we_o,
                             ex_mem_re_o, ex_mem_we_o, ex_branch_o, ex_jump_o, ex_wb_sel_o},
                 {4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00});

        // Load-use: lw x5 then add using x5
        put_instr(32'h104, 5'd5, 5'd2, 5'd0, 1);
        #1 check_eq("lu_pre_hazard", hazard_o, 0);
        step();
        put_instr(32'h108, 5'd7, 5'd5, 5'd6, 0);
        #1 check_eq("lu_hazard", hazard_o, 1);
        step();
        check_eq("lu_bubble_valid", ex_valid_o, 0);
        check_eq("lu_bubble_ctrl", {ex_reg_we_o, ex_mem_re_o, ex_rd_o}, 0);
        check_eq("lu_hazard_clear", hazard_o, 0);
        step();
        check_eq("lu_add_loaded", {ex_valid_o, ex_pc_o, ex_rd_o}, {1'b1, 32'h108, 5'd7});
`ifdef PERF_CNT_EN
        check_eq("lu_cnt", perf_bubble_cnt_o, 1);
`endif

        // x0 and no-match cases
        put_instr(32'h10C, 5'd0, 5'd1, 5'd0, 1);
        step();
        put_instr(32'h110, 5'd6, 5'd0, 5'd0, 1);
        #1 check_eq("x0_hazard", hazard_o, 0);
        step();
        put_instr(32'h114, 5'd3, 5'd5, 5'd7, 0);
        #1 check_eq("nomatch_hazard", hazard_o, 0);
        id_rs2_i = 5'd6;
        #1 check_eq("rs2_match_hazard", hazard_o, 1);
        id_valid_i = 0;
        #1 check_eq("id_invalid_hazard", hazard_o, 0);

        // Invalid ID slot loads as bubble despite set controls
        clear_id();
        id_pc_i = 32'h200; id_reg_we_i = 1; id_jump_i = 1; id_wb_sel_i = 2'b10; id_rd_i = 5'd4;
        step();
        check_eq("empty_load", {ex_valid_o, ex_reg_we_o, ex_jump_o, ex_wb_sel_o, ex_pc_o, ex_rd_o}, 0);

        // Stall holds
        put_instr(32'h300, 5'd9, 5'd1, 5'd2, 0);
        step();
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            put_instr(32'h400 + 32'(i), 5'(10 + i), 5'd3, 5'd4, 0);
            step();
            check_eq("stall_hold", {ex_valid_o, ex_pc_o, ex_rd_o}, {1'b1, 32'h300, 5'd9});
        end
        stall_i = 0;
        put_instr(32'h500, 5'd12, 5'd3, 5'd4, 0);
        step();
        check_eq("stall_release", {ex_valid_o, ex_pc_o, ex_rd_o}, {1'b1, 32'h500, 5'd12});

        // Flush beats stall and hazard
        put_instr(32'h600, 5'd8, 5'd1, 5'd0, 1);
        step();
        put_instr(32'h604, 5'd2, 5'd8, 5'd8, 0);
        flush_i = 1; stall_i = 1;
        #1 check_eq("fl_hazard", hazard_o, 1);
        step();
        flush_i = 0; stall_i = 0;
        check_eq("fl_bubble", {ex_valid_o, ex_mem_re_o, ex_pc_o}, 0);
`ifdef PERF_CNT_EN
        check_eq("fl_cnt", perf_bubble_cnt_o, 1);
`endif
        // Stall with a live hazard holds the load, no bubble counted
        put_instr(32'h608, 5'd8, 5'd1, 5'd0, 1);
        step();
        put_instr(32'h60C, 5'd2, 5'd8, 5'd0, 0);
        stall_i = 1;
        step();
        check_eq("st_hz_hold", {ex_valid_o, ex_mem_re_o, ex_rd_o}, {1'b1, 1'b1, 5'd8});
        check_eq("st_hz_hazard", hazard_o, 1);
        stall_i = 0;
        step();
        check_eq("st_hz_bubble", ex_valid_o, 0);
`ifdef PERF_CNT_EN
        check_eq("st_hz_cnt", perf_bubble_cnt_o, 2);
        // Saturation: 15 more hazards from 2 must stop at 15
        for (int k = 0; k < 15; k++) begin
            put_instr(32'h700, 5'd8, 5'd1, 5'd0, 1);
            step();
            put_instr(32'h704, 5'd2, 5'd8, 5'd0, 0);
            step();
        end
        check_eq("sat_cnt", perf_bubble_cnt_o, 15);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
